stripe_writeback: RTL and testbench

- Receiving end of the three-lane skewed stripe stream the padded-image streamer feeds to the systolic array.
- Deskews lanes 0/1/2, strips the 1-pixel zero padding and writes the interior image back into an array memory over a {row,col} write port.
- Checks stripe-overlap consistency and padding, so it serves both as a loop-back checker for the streamer and as a feature-map writeback stage.

---
 rtl/cnn_pkg.sv | 31 +++
 rtl/lane_deskew.sv | 31 +++
 rtl/stripe_writeback.sv | 185 ++++++++++++++++++
 tb/tb_stripe_writeback.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the stripe writeback path: pixel width, the
// {row,col} address packing used by the array memory, the frame FSM
// encoding and the error-flag bit positions.
package cnn_pkg;

    localparam int DW = 16;

    localparam int ERR_PAD = 0;
    localparam int ERR_OVL = 1;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [15:0] pack_addr(input logic [7:0] row, input logic [7:0] col);
        return {row, col};
    endfunction

    function automatic logic [7:0] addr_row(input logic [15:0] addr);
        return addr[15:8];
    endfunction

    function automatic logic [7:0] addr_col(input logic [15:0] addr);
        return addr[7:0];
    endfunction

endpackage

// File: rtl/lane_deskew.sv
// Fixed-depth delay line used to re-align the skewed stripe lanes.
// A synchronous flush empties every stage so in-flight data is discarded.
module lane_deskew #(
    parameter int W     = 16,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] pipe [DEPTH];

    // Shift register: load stage 0, push older samples down, clear on flush.
    // NOTE: clocked state uses <= so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/stripe_writeback.sv
// Receiving end of the three-lane skewed stripe stream. Re-aligns the lanes,
// strips the one-pixel zero border, writes the interior image into the array
// memory and flags padding or stripe-overlap inconsistencies.
module stripe_writeback #(
    parameter int IMG = 14,
    parameter int DW  = cnn_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] lane0,
    input  logic [DW-1:0] lane1,
    input  logic [DW-1:0] lane2,
    output logic          mem_we,
    output logic [15:0]   mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err
);

    import cnn_pkg::*;

    localparam int PAD     = 1;
    localparam int SIZE    = IMG + 2 * PAD;
    localparam int NSTRIPE = SIZE - 2;
    localparam int NBEAT   = NSTRIPE * SIZE;
    localparam int IDX_W   = $clog2(SIZE);

    localparam logic [7:0]  COL_FIRST = 8'(PAD);
    localparam logic [7:0]  COL_IMG   = 8'(IMG);
    localparam logic [7:0]  COL_LAST  = 8'(SIZE - 1);
    localparam logic [7:0]  ROW_LAST  = 8'(NSTRIPE - 1);
    localparam logic [15:0] BEAT_LAST = 16'(NBEAT - 1);

    state_t state, state_nx;

    logic [DW-1:0] a0, a1, a2;
    logic          d_valid;

    logic [15:0]   beat_cnt;
    logic [7:0]    row_cnt;
    logic [7:0]    col_cnt;

    logic [DW-1:0] prev_l1 [SIZE];
    logic [DW-1:0] prev_l2 [SIZE];

    logic [IDX_W-1:0] col_idx;
    logic             beat_fire;
    logic             edge_col;
    logic             wr_col;
    logic             pad_hit;
    logic             ovl_hit;

    // Lane 2 arrives last, so lane 0 waits two beats and lane 1 one beat.
    lane_deskew #(.W(DW), .DEPTH(2)) u_dly_l0 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (start),
        .d     (lane0),
        .q     (a0)
    );

    lane_deskew #(.W(DW), .DEPTH(1)) u_dly_l1 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (start),
        .d     (lane1),
        .q     (a1)
    );

    lane_deskew #(.W(1), .DEPTH(2)) u_dly_v (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (start),
        .d     (in_valid),
        .q     (d_valid)
    );

    assign a2 = lane2;

    // An aligned beat is consumed only while a frame is open; start drops it.
    assign beat_fire = d_valid && !start && (state == ARMED || state == RUN);
    assign col_idx   = col_cnt[IDX_W-1:0];
    assign edge_col  = (col_cnt == '0) || (col_cnt == COL_LAST);
    assign wr_col    = (col_cnt >= COL_FIRST) && (col_cnt <= COL_IMG);

    assign pad_hit = (edge_col && (a0 != '0 || a1 != '0 || a2 != '0))
                  || (row_cnt == '0 && a0 != '0)
                  || (row_cnt == ROW_LAST && a2 != '0);

    assign ovl_hit = (row_cnt != '0)
                  && (a0 != prev_l1[col_idx] || a1 != prev_l2[col_idx]);

    assign busy = (state == ARMED) || (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Frame sequencing; start re-arms from any state.
    // NOTE: state_nx gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = IDLE;
            ARMED:   if (d_valid) state_nx = RUN;
            RUN:     if (d_valid && beat_cnt == BEAT_LAST) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (start) state_nx = ARMED;
    end

    // Beat, column and stripe counters; column wraps into the next stripe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
        end else if (start) begin
            beat_cnt <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
        end else if (beat_fire) begin
            beat_cnt <= beat_cnt + 16'd1;
            if (col_cnt == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + 8'd1;
            end else begin
                col_cnt <= col_cnt + 8'd1;
            end
        end
    end

    // Row buffers hold the previous stripe's lanes 1/2 for the overlap check.
    // NOTE: these buffers are reset because stripe 0 is never compared, yet
    // a defined power-up value keeps the check free of X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) begin
                prev_l1[i] <= '0;
                prev_l2[i] <= '0;
            end
        end else if (beat_fire) begin
            prev_l1[col_idx] <= a1;
            prev_l2[col_idx] <= a2;
        end
    end

    // Sticky error flags, cleared only by start or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= '0;
        end else if (start) begin
            err <= '0;
        end else if (beat_fire) begin
            if (pad_hit) err[ERR_PAD] <= 1'b1;
            if (ovl_hit) err[ERR_OVL] <= 1'b1;
        end
    end

    // Interior columns are written one cycle after the aligned beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else if (start) begin
            mem_we <= 1'b0;
        end else begin
            mem_we <= beat_fire && wr_col;
            if (beat_fire && wr_col) begin
                mem_addr <= pack_addr(row_cnt, col_cnt - COL_FIRST);
                mem_data <= a1;
            end
        end
    end

endmodule

// File: tb/tb_stripe_writeback.sv
// Bench for stripe_writeback at IMG=4: a padded-image streamer model drives
// the skewed lanes, a monitor logs writes and done pulses, and each frame's
// log is compared against the interior image expected from the same model.
module tb_stripe_writeback;

    localparam int IMG   = 4;
    localparam int DW    = 16;
    localparam int SIZE  = IMG + 2;
    localparam int NBEAT = IMG * SIZE;
    localparam int NSLOT = NBEAT + 16;
    localparam int NVEC  = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] lane0, lane1, lane2;
    logic          mem_we;
    logic [15:0]   mem_addr;
    logic [DW-1:0] mem_data;
    logic          busy;
    logic          done;
    logic [1:0]    err;

    always #5 clk = ~clk;

    stripe_writeback #(.IMG(IMG), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .lane0    (lane0),
        .lane1    (lane1),
        .lane2    (lane2),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    typedef struct {
        string      name;
        int         gap_at;
        int         gap_len;
        int         ovr_lane;
        int         ovr_beat;
        int         ovr_val;
        logic [1:0] exp_err;
        bit         chk_lat;
    } vec_t;

    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int ovr_lane = -1;
    int ovr_beat = -1;
    int ovr_val  = 0;

    logic [31:0] wr_log [$];
    int          done_cnt     = 0;
    int          first_we_cyc = -1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_log.push_back({mem_addr, mem_data});
            if (first_we_cyc < 0) first_we_cyc = cyc;
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Padded image: zero border around a row-major 0..IMG*IMG-1 interior.
    function automatic int pix(input int y, input int x);
        if (y >= 1 && y <= IMG && x >= 1 && x <= IMG) return (y - 1) * IMG + (x - 1);
        return 0;
    endfunction

    function automatic logic [DW-1:0] lane_val(input int lane, input int beat);
        int v;
        if (beat < 0) return '0;
        if (lane == ovr_lane && beat == ovr_beat) v = ovr_val;
        else v = pix(beat / SIZE + lane, beat % SIZE);
        return v[DW-1:0];
    endfunction

    task automatic set_vec(input int i, input string name, input int gap_at, input int gap_len,
                           input int o_lane, input int o_beat, input int o_val,
                           input logic [1:0] e_err, input bit lat);
        vecs[i].name     = name;
        vecs[i].gap_at   = gap_at;
        vecs[i].gap_len  = gap_len;
        vecs[i].ovr_lane = o_lane;
        vecs[i].ovr_beat = o_beat;
        vecs[i].ovr_val  = o_val;
        vecs[i].exp_err  = e_err;
        vecs[i].chk_lat  = lat;
    endtask

    task automatic pulse_start();
        start    = 1'b1;
        in_valid = 1'b0;
        lane0    = '0;
        lane1    = '0;
        lane2    = '0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Streams beats 0..max_beats-1 with an optional valid gap, then keeps
    // valid high with zero data. Returns the cycle beat 1 was presented.
    task automatic drive_frame(input bit do_start, input int gap_at, input int gap_len,
                               input int max_beats, output int beat1_cyc);
        int slot_beat [NSLOT];
        bit slot_v    [NSLOT];
        int b = 0;
        for (int t = 0; t < NSLOT; t++) begin
            if (t >= gap_at && t < gap_at + gap_len) begin
                slot_beat[t] = -1;
                slot_v[t]    = 1'b0;
            end else if (b < NBEAT) begin
                slot_beat[t] = b;
                slot_v[t]    = 1'b1;
                b++;
            end else begin
                slot_beat[t] = -1;
                slot_v[t]    = 1'b1;
            end
        end
        if (do_start) pulse_start();
        wr_log.delete();
        done_cnt     = 0;
        first_we_cyc = -1;
        beat1_cyc    = -1;
        for (int t = 0; t < NSLOT; t++) begin
            if (slot_v[t] && slot_beat[t] >= max_beats) break;
            in_valid = slot_v[t];
            lane0    = lane_val(0, slot_beat[t]);
            lane1    = (t >= 1) ? lane_val(1, slot_beat[t-1]) : '0;
            lane2    = (t >= 2) ? lane_val(2, slot_beat[t-2]) : '0;
            if (slot_beat[t] == 1) beat1_cyc = cyc;
            @(posedge clk); #1;
        end
    endtask

    task automatic finish_frame();
        int n = 0;
        in_valid = 1'b0;
        lane0    = '0;
        lane1    = '0;
        lane2    = '0;
        while (busy && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_writes(input string tag);
        logic [15:0] a;
        logic [7:0]  rr, cc;
        int          r, c;
        check($sformatf("%s n_writes", tag), wr_log.size(), IMG * IMG);
        for (int i = 0; i < IMG * IMG; i++) begin
            r  = i / IMG;
            c  = i % IMG + 1;
            rr = r[7:0];
            cc = 8'(c - 1);
            a  = {rr, cc};
            if (i < wr_log.size())
                check($sformatf("%s write %0d", tag, i), wr_log[i], {a, lane_val(1, r * SIZE + c)});
        end
    endtask

    task automatic check_frame_end(input string tag, input logic [1:0] e_err);
        check({tag, " busy"}, busy, 0);
        check({tag, " done_cnt"}, done_cnt, 1);
        check({tag, " err"}, err, e_err);
        check_writes(tag);
    endtask

    initial begin
        int b1;

        set_vec(0, "clean",      0, 0, -1, -1,  0, 2'b00, 1'b1);
        set_vec(1, "pad_lane0",  0, 0,  0,  2,  5, 2'b01, 1'b0);
        set_vec(2, "ovl_lane1",  0, 0,  1, 15, 99, 2'b10, 1'b0);
        set_vec(3, "gap",        9, 3, -1, -1,  0, 2'b00, 1'b1);
        set_vec(4, "pad_lane2",  0, 0,  2, 20, -1, 2'b01, 1'b0);
        set_vec(5, "edge_lane1", 0, 0,  1,  6,  7, 2'b11, 1'b0);

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        lane0    = '0;
        lane1    = '0;
        lane2    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset mem_we",   mem_we,   0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_data", mem_data, 0);
        check("reset busy",     busy,     0);
        check("reset done",     done,     0);
        check("reset err",      err,      0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < NVEC; v++) begin
            ovr_lane = vecs[v].ovr_lane;
            ovr_beat = vecs[v].ovr_beat;
            ovr_val  = vecs[v].ovr_val;
            drive_frame(1'b1, vecs[v].gap_at, vecs[v].gap_len, NBEAT, b1);
            finish_frame();
            check_frame_end(vecs[v].name, vecs[v].exp_err);
            if (vecs[v].chk_lat)
                check({vecs[v].name, " latency"}, first_we_cyc - b1, 3);
        end

        // Restart mid-frame: a dirty partial frame, then start and a clean frame.
        ovr_lane = 0;
        ovr_beat = 2;
        ovr_val  = 5;
        drive_frame(1'b1, 0, 0, 10, b1);
        check("restart err before", err, 2'b01);
        check("restart busy before", busy, 1);
        ovr_lane = -1;
        ovr_beat = -1;
        ovr_val  = 0;
        pulse_start();
        check("restart err after start", err, 0);
        check("restart mem_we after start", mem_we, 0);
        check("restart busy after start", busy, 1);
        drive_frame(1'b0, 0, 0, NBEAT, b1);
        finish_frame();
        check_frame_end("restart", 2'b00);

        // Asynchronous reset mid-frame, then a normal frame.
        ovr_lane = 0;
        ovr_beat = 2;
        ovr_val  = 5;
        drive_frame(1'b1, 0, 0, 12, b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst mem_we",   mem_we,   0);
        check("async rst mem_addr", mem_addr, 0);
        check("async rst mem_data", mem_data, 0);
        check("async rst busy",     busy,     0);
        check("async rst done",     done,     0);
        check("async rst err",      err,      0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        ovr_lane = -1;
        ovr_beat = -1;
        ovr_val  = 0;
        drive_frame(1'b1, 0, 0, NBEAT, b1);
        finish_frame();
        check_frame_end("after reset", 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
